// File: rtl/mdio_c45_regif_bridge_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : mdio_c45_regif_bridge_if
// Purpose  : Bundles the frame-input, register-bus and response signals of
//            the MDIO clause-45 register-interface bridge.
//            master = bridge side, slave = frame source / register target.
// Revision : 1.0 - initial release
// ============================================================================
interface mdio_c45_regif_bridge_if #(
  parameter int DATA_W = 16,
  parameter int REG_AW = 16,
  parameter int DEV_W  = 5
) ();
  // Frame input
  logic [13:0]             in_info;
  logic                    in_info_en;
  logic [DATA_W-1:0]       in_data;
  logic                    in_data_en;
  // Register bus
  logic [DATA_W-1:0]       reg_if_rdata;
  logic                    reg_if_ready;
  logic [DEV_W+REG_AW-1:0] reg_if_addr;
  logic [DATA_W-1:0]       reg_if_wdata;
  logic                    reg_if_valid;
  logic                    reg_if_we;
  // Response
  logic [DATA_W-1:0]       resp_rdata;
  logic                    resp_ready;
  logic                    resp_err;

  modport master (
    input  in_info, in_info_en, in_data, in_data_en, reg_if_rdata, reg_if_ready,
    output reg_if_addr, reg_if_wdata, reg_if_valid, reg_if_we,
           resp_rdata, resp_ready, resp_err
  );

  modport slave (
    output in_info, in_info_en, in_data, in_data_en, reg_if_rdata, reg_if_ready,
    input  reg_if_addr, reg_if_wdata, reg_if_valid, reg_if_we,
           resp_rdata, resp_ready, resp_err
  );
endinterface
`default_nettype wire

// File: rtl/mdio_c45_regif_bridge.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : mdio_c45_regif_bridge
// Purpose  : Converts MDIO clause-45 frames (address / write / read /
//            read-post-increment) into single accesses on a simple
//            valid/ready register bus. One address register per MMD.
// Options  : MDIO_BRIDGE_TIMEOUT_EN - abort a bus access that is not
//            acknowledged within TIMEOUT_CYC cycles (all-ones data + error).
// Revision : 1.0 - initial release
// ============================================================================
module mdio_c45_regif_bridge #(
  parameter int DATA_W      = 16,
  parameter int REG_AW      = 16,
  parameter int DEV_W       = 5,
  parameter int NUM_MMD     = 4,
  parameter int TIMEOUT_CYC = 64
) (
  input  logic clk_25m,
  input  logic rst,
  input  logic enable,
  output logic busy,
  mdio_c45_regif_bridge_if.master bus
);

  localparam logic [1:0] OP_ADDR  = 2'b00;
  localparam logic [1:0] OP_WRITE = 2'b01;
  localparam logic [1:0] OP_RDINC = 2'b10;
  localparam int         IDX_W    = (NUM_MMD > 1) ? $clog2(NUM_MMD) : 1;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_WAIT_DATA = 2'd1,
    ST_ISSUE     = 2'd2
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  // Latched frame context
  logic [1:0]             r_op;
  logic [DEV_W-1:0]       r_devad;

  // Output registers
  logic [DEV_W+REG_AW-1:0] r_addr_out;
  logic [DATA_W-1:0]       r_wdata;
  logic                    r_valid;
  logic                    r_we;
  logic [DATA_W-1:0]       r_rdata;
  logic                    r_resp_ready;
  logic                    r_resp_err;

  // FSM action strobes
  logic w_hdr_take;
  logic w_err;
  logic w_addr_load;
  logic w_wdata_load;
  logic w_start;
  logic w_done;
  logic w_tmo;
  logic w_tmo_hit;
  logic w_incr;

  // Header decode
  logic [1:0]        w_hdr_op;
  logic [DEV_W-1:0]  w_hdr_dev;
  logic              w_hdr_dev_ok;
  logic              w_unused_info;

  assign w_hdr_op      = bus.in_info[11:10];
  assign w_hdr_dev     = bus.in_info[DEV_W-1:0];
  assign w_hdr_dev_ok  = (int'(w_hdr_dev) < NUM_MMD);
  assign w_unused_info = ^{bus.in_info[13:12], bus.in_info[9:DEV_W]};

  // Reads launch straight from the header, writes from the latched context
  logic [DEV_W-1:0]  w_sel_dev;
  logic [IDX_W-1:0]  w_sel_idx;
  logic [REG_AW-1:0] w_addr_arr [NUM_MMD];

  assign w_sel_dev = (r_state == ST_IDLE) ? w_hdr_dev : r_devad;
  assign w_sel_idx = w_sel_dev[IDX_W-1:0];
  assign w_incr    = w_done && (r_op == OP_RDINC);

  generate
    for (genvar gi = 0; gi < NUM_MMD; gi++) begin : g_mmd
      logic [REG_AW-1:0] r_addr;
      logic              w_hit;

      assign w_hit = (r_devad == DEV_W'(gi));

      // Per-MMD address register: loaded by address frames, bumped by read-post-increment
      always_ff @(posedge clk_25m or posedge rst) begin
        if (rst) begin
          r_addr <= '0;
        end else if (w_hit && w_addr_load) begin
          r_addr <= bus.in_data[REG_AW-1:0];
        end else if (w_hit && w_incr) begin
          r_addr <= r_addr + REG_AW'(1);
        end
      end

      assign w_addr_arr[gi] = r_addr;
    end
  endgenerate

`ifdef MDIO_BRIDGE_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYC + 1);
  logic [TO_W-1:0] r_to_cnt;

  // Counts unacknowledged ISSUE cycles; restarts on every new access
  always_ff @(posedge clk_25m or posedge rst) begin
    if (rst) begin
      r_to_cnt <= '0;
    end else if (w_start || (r_state != ST_ISSUE)) begin
      r_to_cnt <= '0;
    end else if (!bus.reg_if_ready) begin
      r_to_cnt <= r_to_cnt + TO_W'(1);
    end
  end

  assign w_tmo_hit = (r_to_cnt == TO_W'(TIMEOUT_CYC - 1));
`else
  assign w_tmo_hit = 1'b0;
`endif

  // State register
  always_ff @(posedge clk_25m or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state and action strobes; enable low flushes to IDLE with no actions
  always_comb begin
    w_state_nxt  = r_state;
    w_hdr_take   = 1'b0;
    w_err        = 1'b0;
    w_addr_load  = 1'b0;
    w_wdata_load = 1'b0;
    w_start      = 1'b0;
    w_done       = 1'b0;
    w_tmo        = 1'b0;
    if (!enable) begin
      w_state_nxt = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (bus.in_info_en) begin
            if (w_hdr_dev_ok) begin
              w_hdr_take = 1'b1;
              if ((w_hdr_op == OP_ADDR) || (w_hdr_op == OP_WRITE)) begin
                w_state_nxt = ST_WAIT_DATA;
              end else begin
                w_start     = 1'b1;
                w_state_nxt = ST_ISSUE;
              end
            end else begin
              w_err = 1'b1;
            end
          end
        end
        ST_WAIT_DATA: begin
          w_err = bus.in_info_en;
          if (bus.in_data_en) begin
            if (r_op == OP_ADDR) begin
              w_addr_load = 1'b1;
              w_state_nxt = ST_IDLE;
            end else begin
              w_wdata_load = 1'b1;
              w_start      = 1'b1;
              w_state_nxt  = ST_ISSUE;
            end
          end
        end
        ST_ISSUE: begin
          w_err = bus.in_info_en;
          if (bus.reg_if_ready) begin
            w_done      = 1'b1;
            w_state_nxt = ST_IDLE;
          end else if (w_tmo_hit) begin
            w_tmo       = 1'b1;
            w_state_nxt = ST_IDLE;
          end
        end
        default: begin
          w_state_nxt = ST_IDLE;
        end
      endcase
    end
  end

  // Datapath and output registers driven by the FSM strobes
  always_ff @(posedge clk_25m or posedge rst) begin
    if (rst) begin
      r_op         <= '0;
      r_devad      <= '0;
      r_addr_out   <= '0;
      r_wdata      <= '0;
      r_valid      <= 1'b0;
      r_we         <= 1'b0;
      r_rdata      <= '0;
      r_resp_ready <= 1'b0;
      r_resp_err   <= 1'b0;
    end else begin
      r_resp_ready <= 1'b0;
      r_resp_err   <= w_err;
      if (!enable) begin
        r_valid <= 1'b0;
        r_we    <= 1'b0;
      end
      if (w_hdr_take) begin
        r_op    <= w_hdr_op;
        r_devad <= w_hdr_dev;
      end
      if (w_wdata_load) begin
        r_wdata <= bus.in_data;
      end
      if (w_start) begin
        r_valid    <= 1'b1;
        r_we       <= (r_state == ST_WAIT_DATA);
        r_addr_out <= {w_sel_dev, w_addr_arr[w_sel_idx]};
      end
      if (w_done) begin
        r_valid      <= 1'b0;
        r_we         <= 1'b0;
        r_resp_ready <= 1'b1;
        if (!r_we) begin
          r_rdata <= bus.reg_if_rdata;
        end
      end
      if (w_tmo) begin
        r_valid      <= 1'b0;
        r_we         <= 1'b0;
        r_resp_ready <= 1'b1;
        r_resp_err   <= 1'b1;
        r_rdata      <= '1;
      end
    end
  end

  assign busy             = (r_state != ST_IDLE);
  assign bus.reg_if_addr  = r_addr_out;
  assign bus.reg_if_wdata = r_wdata;
  assign bus.reg_if_valid = r_valid;
  assign bus.reg_if_we    = r_we;
  assign bus.resp_rdata   = r_rdata;
  assign bus.resp_ready   = r_resp_ready;
  assign bus.resp_err     = r_resp_err;

endmodule
`default_nettype wire

// File: tb/tb_mdio_c45_regif_bridge.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_mdio_c45_regif_bridge
// Purpose  : Self-checking bench for mdio_c45_regif_bridge: directed frames
//            plus randomized frame sequences against a register-map model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mdio_c45_regif_bridge;

  localparam logic [1:0] OP_ADDR  = 2'b00;
  localparam logic [1:0] OP_WRITE = 2'b01;
  localparam logic [1:0] OP_RDINC = 2'b10;
  localparam logic [1:0] OP_READ  = 2'b11;
  localparam int         NMMD     = 4;

  logic clk_25m = 1'b0;
  logic rst;
  logic enable;
  logic busy;

  mdio_c45_regif_bridge_if #(.DATA_W(16), .REG_AW(16), .DEV_W(5)) bus ();

  mdio_c45_regif_bridge #(
    .DATA_W(16), .REG_AW(16), .DEV_W(5), .NUM_MMD(NMMD), .TIMEOUT_CYC(64)
  ) dut (
    .clk_25m (clk_25m),
    .rst     (rst),
    .enable  (enable),
    .busy    (busy),
    .bus     (bus)
  );

  always #20 clk_25m = ~clk_25m;

  // Reference model: per-MMD address map and last read response
  logic [15:0] mdl_addr [NMMD];
  logic [15:0] mdl_rdata;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk_25m);
    #1;
  endtask

  task automatic send_header(input logic [1:0] op, input int dev);
    logic [4:0] d5;
    d5 = dev[4:0];
    bus.in_info    = {2'($urandom), op, 5'($urandom), d5};
    bus.in_info_en = 1'b1;
    tick();
    bus.in_info_en = 1'b0;
  endtask

  task automatic send_data(input logic [15:0] d);
    bus.in_data    = d;
    bus.in_data_en = 1'b1;
    tick();
    bus.in_data_en = 1'b0;
  endtask

  // One complete frame sequence; ready returns after dly cycles with rd
  task automatic do_txn(input logic [1:0] op, input int dev, input logic [15:0] data,
                        input int dly, input logic [15:0] rd, input bit inject);
    logic [4:0]  d5;
    logic [20:0] exp_a;
    d5 = dev[4:0];
    send_header(op, dev);
    if (dev >= NMMD) begin
      check_eq("bad_dev_err", bus.resp_err, 1);
      check_eq("bad_dev_valid", bus.reg_if_valid, 0);
      check_eq("bad_dev_busy", busy, 0);
      tick();
      check_eq("bad_dev_err_clr", bus.resp_err, 0);
      return;
    end
    if ((op == OP_ADDR) || (op == OP_WRITE)) begin
      check_eq("wait_busy", busy, 1);
      check_eq("wait_valid", bus.reg_if_valid, 0);
      send_data(data);
      if (op == OP_ADDR) begin
        check_eq("addr_busy", busy, 0);
        check_eq("addr_valid", bus.reg_if_valid, 0);
        mdl_addr[dev] = data;
        return;
      end
    end
    exp_a = {d5, mdl_addr[dev]};
    check_eq("issue_valid", bus.reg_if_valid, 1);
    check_eq("issue_addr", bus.reg_if_addr, exp_a);
    check_eq("issue_we", bus.reg_if_we, (op == OP_WRITE) ? 1 : 0);
    if (op == OP_WRITE) check_eq("issue_wdata", bus.reg_if_wdata, data);
    for (int i = 0; i < dly; i++) begin
      if (inject && (i == 0)) begin
        bus.in_info    = {2'b00, OP_READ, 5'b0, 5'($urandom_range(0, 3))};
        bus.in_info_en = 1'b1;
        bus.in_data    = 16'($urandom);
        bus.in_data_en = 1'b1;
      end
      tick();
      bus.in_info_en = 1'b0;
      bus.in_data_en = 1'b0;
      if (inject && (i == 0)) check_eq("busy_hdr_err", bus.resp_err, 1);
    end
    check_eq("hold_valid", bus.reg_if_valid, 1);
    check_eq("hold_addr", bus.reg_if_addr, exp_a);
    if (op == OP_WRITE) check_eq("hold_wdata", bus.reg_if_wdata, data);
    bus.reg_if_ready = 1'b1;
    bus.reg_if_rdata = rd;
    tick();
    bus.reg_if_ready = 1'b0;
    bus.reg_if_rdata = 16'($urandom);
    if (op != OP_WRITE) mdl_rdata = rd;
    if (op == OP_RDINC) mdl_addr[dev] = mdl_addr[dev] + 16'd1;
    check_eq("done_resp_ready", bus.resp_ready, 1);
    check_eq("done_valid", bus.reg_if_valid, 0);
    check_eq("done_we", bus.reg_if_we, 0);
    check_eq("done_busy", busy, 0);
    check_eq("done_rdata", bus.resp_rdata, mdl_rdata);
    tick();
    check_eq("resp_ready_pulse", bus.resp_ready, 0);
  endtask

  initial begin
    logic [1:0]  r_op;
    int          r_dev;
    int          r_dly;
    logic [15:0] r_data;
    bit          r_inj;
    int          k;

    rst              = 1'b1;
    enable           = 1'b1;
    bus.in_info      = '0;
    bus.in_info_en   = 1'b0;
    bus.in_data      = '0;
    bus.in_data_en   = 1'b0;
    bus.reg_if_rdata = '0;
    bus.reg_if_ready = 1'b0;
    for (int i = 0; i < NMMD; i++) mdl_addr[i] = 16'h0;
    mdl_rdata = 16'h0;

    repeat (2) tick();
    check_eq("rst_addr", bus.reg_if_addr, 0);
    check_eq("rst_wdata", bus.reg_if_wdata, 0);
    check_eq("rst_valid", bus.reg_if_valid, 0);
    check_eq("rst_we", bus.reg_if_we, 0);
    check_eq("rst_rdata", bus.resp_rdata, 0);
    check_eq("rst_resp_ready", bus.resp_ready, 0);
    check_eq("rst_resp_err", bus.resp_err, 0);
    check_eq("rst_busy", busy, 0);
    rst = 1'b0;
    tick();

    // Address then read on MMD 1
    do_txn(OP_ADDR, 1, 16'h0010, 0, 16'h0, 0);
    do_txn(OP_READ, 1, 16'h0, 3, 16'hBEEF, 0);
    check_eq("dir_read_rdata", bus.resp_rdata, 16'hBEEF);

    // Post-increment wrap on MMD 2
    do_txn(OP_ADDR, 2, 16'hFFFF, 0, 16'h0, 0);
    do_txn(OP_RDINC, 2, 16'h0, 1, 16'h1111, 0);
    do_txn(OP_RDINC, 2, 16'h0, 2, 16'h2222, 0);
    check_eq("dir_wrap_model", mdl_addr[2], 16'h0001);

    // Write on MMD 3 leaves its address register alone
    do_txn(OP_ADDR, 3, 16'h0004, 0, 16'h0, 0);
    do_txn(OP_WRITE, 3, 16'h1234, 4, 16'h5555, 0);
    do_txn(OP_READ, 3, 16'h0, 0, 16'h0A0A, 0);

    // Out-of-range DEVAD, then header and data strobes during ISSUE
    do_txn(OP_READ, 7, 16'h0, 0, 16'h0, 0);
    do_txn(OP_READ, 1, 16'h0, 3, 16'hC0DE, 1);

    // Stray ready / data while idle are ignored
    bus.reg_if_ready = 1'b1;
    bus.in_data     = 16'hDEAD;
    bus.in_data_en  = 1'b1;
    tick();
    bus.reg_if_ready = 1'b0;
    bus.in_data_en   = 1'b0;
    check_eq("idle_ready_ign", bus.resp_ready, 0);
    check_eq("idle_data_busy", busy, 0);
    do_txn(OP_READ, 1, 16'h0, 0, 16'h7777, 0);

    // Enable flush in the middle of an access
    send_header(OP_READ, 2);
    check_eq("flush_pre_valid", bus.reg_if_valid, 1);
    enable = 1'b0;
    tick();
    enable = 1'b1;
    check_eq("flush_valid", bus.reg_if_valid, 0);
    check_eq("flush_busy", busy, 0);
    check_eq("flush_resp", bus.resp_ready, 0);
    bus.reg_if_ready = 1'b1;
    tick();
    bus.reg_if_ready = 1'b0;
    check_eq("flush_late_ready", bus.resp_ready, 0);
    do_txn(OP_READ, 2, 16'h0, 1, 16'h3C3C, 0);

`ifdef MDIO_BRIDGE_TIMEOUT_EN
    // Unacknowledged post-increment read times out without incrementing
    send_header(OP_RDINC, 3);
    k = 0;
    while ((bus.resp_ready !== 1'b1) && (k < 200)) begin
      tick();
      k++;
    end
    check_eq("tmo_cycles", k, 64);
    check_eq("tmo_rdata", bus.resp_rdata, 16'hFFFF);
    check_eq("tmo_err", bus.resp_err, 1);
    check_eq("tmo_busy", busy, 0);
    check_eq("tmo_valid", bus.reg_if_valid, 0);
    mdl_rdata = 16'hFFFF;
    tick();
    do_txn(OP_READ, 3, 16'h0, 0, 16'h4545, 0);
`endif

    // Randomized frame mix including invalid DEVADs and wrap values
    for (int t = 0; t < 60; t++) begin
      r_op   = 2'($urandom);
      r_dev  = $urandom_range(0, 5);
      r_data = ($urandom_range(0, 3) == 0) ? 16'hFFFF : 16'($urandom);
      r_dly  = $urandom_range(0, 4);
      r_inj  = (r_dly > 0) && ($urandom_range(0, 3) == 0);
      do_txn(r_op, r_dev, r_data, r_dly, 16'($urandom), r_inj);
    end

    // Asynchronous reset in the middle of an access
    send_header(OP_READ, 3);
    check_eq("arst_pre_valid", bus.reg_if_valid, 1);
    #5 rst = 1'b1;
    #1;
    check_eq("arst_valid", bus.reg_if_valid, 0);
    check_eq("arst_busy", busy, 0);
    check_eq("arst_resp", bus.resp_ready, 0);
    check_eq("arst_addr", bus.reg_if_addr, 0);
    tick();
    rst = 1'b0;
    for (int i = 0; i < NMMD; i++) mdl_addr[i] = 16'h0;
    mdl_rdata = 16'h0;
    tick();
    do_txn(OP_READ, 3, 16'h0, 0, 16'h9999, 0);
    do_txn(OP_READ, 1, 16'h0, 1, 16'h8888, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
